clkmeas: RTL and testbench

Reference-clock-domain frequency meter that measures an external clock's average period in `refclk` cycles. It is the receive-side counterpart of the fractional divider `clkdiv`. Given a gate of N rising edges of `clkin`, it reports the `refclk` cycle count spanning them, so that `meas_cnt/gate_edges` equals the divider's `fenzi/fenmu`. It is used for self-check of divider outputs and for calibrating externally sourced clocks.

---
 rtl/clkmeas.sv | 205 ++++++++++++++++++++
 tb/tb_clkmeas.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkmeas.sv
// ---------------------------------------------------------------------------
// clkmeas -- reference-clock-domain frequency meter
//
// Measures the average period of an external clock (clkin) in refclk cycles.
// After an accepted start the block waits for a fresh clkin rising edge, then
// counts refclk cycles until gate_edges further rising edges have been seen.
// The result therefore equals gate_edges * average clkin period, i.e. for a
// fractional divider output meas_cnt / gate_edges == fenzi / fenmu.
//
// Parameters
//   CNT_W        width of the measurement counter and of meas_cnt
//   TIMEOUT_CYC  refclk cycles without a clkin edge before giving up
//
// Ports
//   refclk       single clock, everything runs on its rising edge
//   rstn         asynchronous active-low reset
//   clkin        clock under measurement, asynchronous to refclk
//   start        measurement request, sampled on refclk rising edge
//   gate_edges   number of clkin periods to span, latched on accepted start
//   busy         high while a measurement is armed or running
//   meas_cnt     last result, holds until the next result
//   meas_valid   one-cycle pulse together with a meas_cnt update
//   timeout_err  sticky watchdog flag, cleared by the next accepted start
// ---------------------------------------------------------------------------
module clkmeas #(
    parameter int unsigned CNT_W       = 32,
    parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000
) (
    input  logic             refclk,
    input  logic             rstn,
    input  logic             clkin,
    input  logic             start,
    input  logic [15:0]      gate_edges,
    output logic             busy,
    output logic [CNT_W-1:0] meas_cnt,
    output logic             meas_valid,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       rst_chain;
    logic             rstn_syn;

    logic             clkin_s1;
    logic             clkin_s2;
    logic             clkin_hist;
    logic             edge_det;

    state_t           state;
    state_t           state_nxt;
    logic [15:0]      gate_q;
    logic [15:0]      gate_nxt;
    logic [CNT_W-1:0] ref_cnt;
    logic [CNT_W-1:0] ref_nxt;
    logic [CNT_W-1:0] ref_inc;
    logic [15:0]      edge_cnt;
    logic [15:0]      edge_nxt;
    logic [15:0]      edge_inc;
    logic [31:0]      wdog;
    logic [31:0]      wdog_nxt;
    logic [31:0]      wdog_inc;
    logic             wdog_expire;
    logic [CNT_W-1:0] meas_cnt_nxt;
    logic             valid_nxt;
    logic             terr_nxt;

    // Reset release is pushed through three refclk flops so that leaving
    // reset is glitch-free with respect to refclk. Until the last stage is
    // high, start requests are simply not accepted.
    always_ff @(posedge refclk or negedge rstn) begin
        if (!rstn) begin
            rst_chain <= 3'b000;
        end else begin
            rst_chain <= {rst_chain[1:0], 1'b1};
        end
    end

    assign rstn_syn = rst_chain[2];

    // clkin is asynchronous, so it goes through a two-flop synchronizer.
    // The history flop lets us spot a rising edge as a single-cycle pulse.
    // The 2-3 cycle latency of this path is identical for every edge, so it
    // drops out of the edge-to-edge distance that we actually report.
    always_ff @(posedge refclk or negedge rstn) begin
        if (!rstn) begin
            clkin_s1   <= 1'b0;
            clkin_s2   <= 1'b0;
            clkin_hist <= 1'b0;
        end else begin
            clkin_s1   <= clkin;
            clkin_s2   <= clkin_s1;
            clkin_hist <= clkin_s2;
        end
    end

    assign edge_det = clkin_s2 & ~clkin_hist;

    // Increment helpers. The reference counter saturates rather than wraps,
    // so an over-long gate reports all-ones instead of a small bogus value.
    // edge_cnt never exceeds gate_q-1, so its increment cannot overflow.
    assign ref_inc     = (ref_cnt == CNT_MAX) ? CNT_MAX : (ref_cnt + CNT_ONE);
    assign edge_inc    = edge_cnt + 16'd1;
    assign wdog_inc    = wdog + 32'd1;
    assign wdog_expire = (wdog_inc == TIMEOUT_CYC);

    // All sequential state of the measurement engine lives here; the next
    // values are worked out in the combinational block below.
    always_ff @(posedge refclk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            gate_q      <= 16'd0;
            ref_cnt     <= '0;
            edge_cnt    <= 16'd0;
            wdog        <= 32'd0;
            meas_cnt    <= '0;
            meas_valid  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            gate_q      <= gate_nxt;
            ref_cnt     <= ref_nxt;
            edge_cnt    <= edge_nxt;
            wdog        <= wdog_nxt;
            meas_cnt    <= meas_cnt_nxt;
            meas_valid  <= valid_nxt;
            timeout_err <= terr_nxt;
        end
    end

    // Next-state logic. IDLE waits for a usable start, ARM waits for the
    // first fresh clkin edge to open the gate, MEAS counts refclk cycles
    // until the gate closes on the g-th edge. The watchdog runs in ARM and
    // MEAS; an edge always takes priority over a coincident expiry, so a
    // measurement that just makes it is never thrown away.
    always_comb begin
        state_nxt    = state;
        gate_nxt     = gate_q;
        ref_nxt      = ref_cnt;
        edge_nxt     = edge_cnt;
        wdog_nxt     = wdog;
        meas_cnt_nxt = meas_cnt;
        valid_nxt    = 1'b0;
        terr_nxt     = timeout_err;

        case (state)
            IDLE: begin
                if (start && rstn_syn && (gate_edges != 16'd0)) begin
                    gate_nxt  = gate_edges;
                    terr_nxt  = 1'b0;
                    wdog_nxt  = 32'd0;
                    state_nxt = ARM;
                end
            end

            ARM: begin
                if (edge_det) begin
                    ref_nxt   = '0;
                    edge_nxt  = 16'd0;
                    wdog_nxt  = 32'd0;
                    state_nxt = MEAS;
                end else if (wdog_expire) begin
                    terr_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wdog_nxt  = wdog_inc;
                end
            end

            MEAS: begin
                ref_nxt = ref_inc;
                if (edge_det) begin
                    wdog_nxt = 32'd0;
                    edge_nxt = edge_inc;
                    if (edge_inc == gate_q) begin
                        meas_cnt_nxt = ref_inc;
                        valid_nxt    = 1'b1;
                        state_nxt    = IDLE;
                    end
                end else if (wdog_expire) begin
                    terr_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wdog_nxt  = wdog_inc;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // busy is just "not idle": it rises with ARM entry and drops in the same
    // cycle that meas_valid or timeout_err appears.
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_clkmeas.sv
// ---------------------------------------------------------------------------
// tb_clkmeas -- directed self-checking bench for clkmeas
//
// dut_a : CNT_W=32, TIMEOUT_CYC=100  (ratio, timeout, ignored start, reset)
// dut_b : CNT_W=8,  TIMEOUT_CYC=1000 (result saturation)
// clkin comes from a small fractional-divider model: every refclk cycle an
// accumulator grows by fenmu; when it passes fenzi a rising edge is made and
// clkin stays high for 3 cycles. The average period is fenzi/fenmu.
// ---------------------------------------------------------------------------
module tb_clkmeas;

    logic        refclk = 1'b0;
    logic        rstn = 1'b0;
    logic        clkin = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [15:0] gate_edges = 16'd0;

    logic        busy_a;
    logic [31:0] meas_cnt_a;
    logic        meas_valid_a;
    logic        timeout_err_a;
    logic        busy_b;
    logic [7:0]  meas_cnt_b;
    logic        meas_valid_b;
    logic        timeout_err_b;

    int vectors = 0;
    int miscompares = 0;

    bit gen_en = 1'b0;
    int fenzi = 10;
    int fenmu = 1;
    int acc = 0;
    int phase = 100;

    clkmeas #(.CNT_W(32), .TIMEOUT_CYC(32'd100)) dut_a (
        .refclk      (refclk),
        .rstn        (rstn),
        .clkin       (clkin),
        .start       (start_a),
        .gate_edges  (gate_edges),
        .busy        (busy_a),
        .meas_cnt    (meas_cnt_a),
        .meas_valid  (meas_valid_a),
        .timeout_err (timeout_err_a)
    );

    clkmeas #(.CNT_W(8), .TIMEOUT_CYC(32'd1000)) dut_b (
        .refclk      (refclk),
        .rstn        (rstn),
        .clkin       (clkin),
        .start       (start_b),
        .gate_edges  (gate_edges),
        .busy        (busy_b),
        .meas_cnt    (meas_cnt_b),
        .meas_valid  (meas_valid_b),
        .timeout_err (timeout_err_b)
    );

    // 10 time-unit reference clock.
    always #5 refclk = ~refclk;

    // Fractional divider model, updated on the falling edge so clkin never
    // changes at the instant the DUT samples it.
    always @(negedge refclk) begin
        if (!gen_en) begin
            acc   = 0;
            phase = 100;
            clkin = 1'b0;
        end else begin
            acc = acc + fenmu;
            if (acc >= fenzi) begin
                acc   = acc - fenzi;
                phase = 0;
            end else if (phase < 1000) begin
                phase = phase + 1;
            end
            clkin = (phase < 3);
        end
    end

    // Compares one observed value with its expected value and reports.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Pulses start on dut_a for one cycle with the given gate length.
    task automatic applyStimulus(input logic [15:0] gate);
        @(negedge refclk);
        start_a    = 1'b1;
        gate_edges = gate;
        @(negedge refclk);
        start_a    = 1'b0;
    endtask

    task automatic setClk(input int fz, input int fm);
        @(posedge refclk);
        fenzi  = fz;
        fenmu  = fm;
        acc    = 0;
        gen_en = 1'b1;
        repeat (3) @(negedge refclk);
    endtask

    task automatic stopClk();
        @(posedge refclk);
        gen_en = 1'b0;
        repeat (6) @(negedge refclk);
    endtask

    // Waits (bounded) for the running dut_a measurement to finish and checks
    // result, pulse count, busy at the pulse and the error flag. A non-zero
    // poke_at fires an extra start that many cycles into the wait.
    task automatic waitResult(input logic [31:0] exp_cnt, input string tag,
                              input int poke_at);
        int n;
        int pulses;
        logic [31:0] got;
        logic busy_at_valid;
        n = 0;
        pulses = 0;
        got = 32'd0;
        busy_at_valid = 1'b1;
        if (poke_at > 0) gate_edges = 16'd3;
        while (busy_a && n < 3000) begin
            @(negedge refclk);
            n++;
            if (meas_valid_a) begin
                pulses++;
                got = meas_cnt_a;
                busy_at_valid = busy_a;
            end
            start_a = (poke_at > 0 && n == poke_at);
        end
        start_a = 1'b0;
        checkOutput({tag, "_finished"}, {63'd0, busy_a}, 64'd0);
        repeat (5) begin
            @(negedge refclk);
            if (meas_valid_a) pulses++;
        end
        checkOutput({tag, "_cnt"}, {32'd0, got}, {32'd0, exp_cnt});
        checkOutput({tag, "_pulses"}, pulses, 1);
        checkOutput({tag, "_busy_at_valid"}, {63'd0, busy_at_valid}, 64'd0);
        checkOutput({tag, "_terr"}, {63'd0, timeout_err_a}, 64'd0);
    endtask

    initial begin
        int n;
        int pulses;
        logic [31:0] prev_cnt;

        $display("[TB] clkmeas directed test starting");

        rstn = 1'b0;
        repeat (3) @(negedge refclk);
        checkOutput("rst_busy_a", {63'd0, busy_a}, 64'd0);
        checkOutput("rst_cnt_a", {32'd0, meas_cnt_a}, 64'd0);
        checkOutput("rst_valid_a", {63'd0, meas_valid_a}, 64'd0);
        checkOutput("rst_terr_a", {63'd0, timeout_err_a}, 64'd0);
        checkOutput("rst_busy_b", {63'd0, busy_b}, 64'd0);
        checkOutput("rst_cnt_b", {56'd0, meas_cnt_b}, 64'd0);
        @(negedge refclk);
        rstn = 1'b1;
        repeat (5) @(negedge refclk);

        // Integer ratio: period 10, 8 edges -> 80.
        setClk(10, 1);
        applyStimulus(16'd8);
        checkOutput("int_busy", {63'd0, busy_a}, 64'd1);
        waitResult(32'd80, "int10_g8", 0);

        // Fractional ratio: average period 6.25.
        setClk(25, 4);
        applyStimulus(16'd4);
        waitResult(32'd25, "frac_g4", 0);
        applyStimulus(16'd16);
        waitResult(32'd100, "frac_g16", 0);

        // Ignored starts: zero gate, and a start during MEAS.
        applyStimulus(16'd0);
        checkOutput("zero_gate_busy0", {63'd0, busy_a}, 64'd0);
        repeat (3) @(negedge refclk);
        checkOutput("zero_gate_busy3", {63'd0, busy_a}, 64'd0);
        setClk(10, 1);
        applyStimulus(16'd8);
        waitResult(32'd80, "mid_start", 20);

        // Timeout with clkin held low.
        stopClk();
        prev_cnt = meas_cnt_a;
        applyStimulus(16'd4);
        checkOutput("to_busy", {63'd0, busy_a}, 64'd1);
        n = 0;
        pulses = 0;
        while (!timeout_err_a && n < 300) begin
            @(negedge refclk);
            n++;
            if (meas_valid_a) pulses++;
        end
        checkOutput("to_cycles", n, 100);
        checkOutput("to_terr", {63'd0, timeout_err_a}, 64'd1);
        checkOutput("to_busy_low", {63'd0, busy_a}, 64'd0);
        checkOutput("to_no_valid", pulses, 0);
        checkOutput("to_cnt_hold", {32'd0, meas_cnt_a}, {32'd0, prev_cnt});
        applyStimulus(16'd4);
        checkOutput("to_terr_cleared", {63'd0, timeout_err_a}, 64'd0);
        checkOutput("to_rearm_busy", {63'd0, busy_a}, 64'd1);
        setClk(10, 1);
        waitResult(32'd40, "to_recover", 0);

        // Saturation on the 8-bit instance: 4 x 100 clamps to 255.
        setClk(100, 1);
        @(negedge refclk);
        start_b    = 1'b1;
        gate_edges = 16'd4;
        @(negedge refclk);
        start_b    = 1'b0;
        checkOutput("sat_busy", {63'd0, busy_b}, 64'd1);
        n = 0;
        pulses = 0;
        while (busy_b && n < 3000) begin
            @(negedge refclk);
            n++;
            if (meas_valid_b) pulses++;
        end
        checkOutput("sat_finished", {63'd0, busy_b}, 64'd0);
        checkOutput("sat_cnt", {56'd0, meas_cnt_b}, 64'd255);
        checkOutput("sat_pulses", pulses, 1);
        checkOutput("sat_terr", {63'd0, timeout_err_b}, 64'd0);

        // Reset in the middle of a measurement, then a clean restart.
        setClk(10, 1);
        applyStimulus(16'd8);
        repeat (30) @(negedge refclk);
        rstn = 1'b0;
        #1;
        checkOutput("mid_rst_busy", {63'd0, busy_a}, 64'd0);
        checkOutput("mid_rst_cnt_a", {32'd0, meas_cnt_a}, 64'd0);
        checkOutput("mid_rst_valid", {63'd0, meas_valid_a}, 64'd0);
        checkOutput("mid_rst_terr", {63'd0, timeout_err_a}, 64'd0);
        checkOutput("mid_rst_cnt_b", {56'd0, meas_cnt_b}, 64'd0);
        @(negedge refclk);
        rstn       = 1'b1;
        start_a    = 1'b1;
        gate_edges = 16'd8;
        for (int i = 1; i <= 3; i++) begin
            @(negedge refclk);
            checkOutput($sformatf("rel_ignore_%0d", i), {63'd0, busy_a}, 64'd0);
        end
        @(negedge refclk);
        checkOutput("rel_accept", {63'd0, busy_a}, 64'd1);
        start_a = 1'b0;
        waitResult(32'd80, "post_reset", 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
